// File: rtl/c1541_pkg.sv
// Shared types and helpers for the 1541 GCR track buffer controller.
package c1541_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      FLUSH_REQ,
      FLUSH_WAIT,
      LOAD_REQ,
      LOAD_WAIT
   } state_t;

   localparam int TRACK_BYTES = 8192;
   localparam int TRK_W       = 6;

   // Odd and even half-tracks share the lower whole track; clamp to the image size.
   function automatic logic [TRK_W-1:0] half_to_track(input logic [6:0]       half,
                                                      input logic [TRK_W-1:0] max_trk);
      logic [TRK_W-1:0] whole;
      whole = half[6:1];
      return (whole > max_trk) ? max_trk : whole;
   endfunction

endpackage

// File: rtl/c1541_sd_block_xfer.sv
// Single-block SD request/ack handshake: gates the request against sd_ack and
// reports the rising and falling edges of the host acknowledge.
module c1541_sd_block_xfer (
   input  logic clk,
   input  logic rst_n,
   input  logic req_rd,
   input  logic req_wr,
   input  logic sd_ack,
   output logic sd_rd,
   output logic sd_wr,
   output logic ack_rise,
   output logic done
);

   logic ack_q;
   logic ack_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q <= 1'b0;
      end else begin
         ack_q <= ack_d;
      end
   end

   // Requests drop combinationally the moment the host acknowledges, and read wins a clash.
   always_comb begin
      ack_d    = sd_ack;
      sd_rd    = req_rd & ~sd_ack;
      sd_wr    = req_wr & ~req_rd & ~sd_ack;
      ack_rise = sd_ack & ~ack_q;
      done     = ~sd_ack & ack_q;
   end

endmodule

// File: rtl/c1541_track_ctrl.sv
// Track buffer sequencer for the 1541: flushes the dirty resident track to the SD
// image and loads the selected one. Optional macro C1541_FLUSH_ON_MTR_OFF_EN adds a flush on motor-off.
module c1541_track_ctrl
   import c1541_pkg::*;
#(
   parameter int TRACK_BLOCKS = 16,
   parameter int NUM_TRACKS   = 42,
   parameter int SETTLE_CYC   = 32000
) (
   input  logic                           clk32,
   input  logic                           reset_n,
   input  logic                           img_mounted,
   input  logic                           img_readonly,
   input  logic [31:0]                    img_base_lba,
   input  logic [6:0]                     half_track,
   input  logic                           mtr,
   input  logic                           gcr_ram_we,
   output logic                           ram_ready,
   output logic                           busy,
   output logic [31:0]                    sd_lba,
   output logic                           sd_rd,
   output logic                           sd_wr,
   input  logic                           sd_ack,
   input  logic [8:0]                     sd_buff_addr,
   input  logic                           sd_buff_wr,
   output logic [$clog2(TRACK_BYTES)-1:0] tbuf_addr,
   output logic                           tbuf_we
);

   localparam int               BW         = $clog2(TRACK_BLOCKS);
   localparam int               TW         = $clog2(SETTLE_CYC);
   localparam logic [BW-1:0]    LAST_BLK   = BW'(TRACK_BLOCKS - 1);
   localparam logic [TW-1:0]    SETTLE_END = TW'(SETTLE_CYC - 1);
   localparam logic [TRK_W-1:0] MAX_TRK    = TRK_W'(NUM_TRACKS - 1);

   state_t           state_q, state_d;
   logic [BW-1:0]    blk_q, blk_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [TRK_W-1:0] cur_track_q, cur_track_d;
   logic [TRK_W-1:0] new_track_q, new_track_d;
   logic [TRK_W-1:0] prev_req_q;
   logic             valid_q, valid_d;
   logic             dirty_q, dirty_d;
   logic             mounted_q, mounted_d;
   logic             mount_pend_q, mount_pend_d;
   logic             flush_only_q, flush_only_d;
   logic             ram_ready_q;
   logic [31:0]      sd_lba_q, sd_lba_d;

   logic [TRK_W-1:0] req_track;
   logic             req_rd, req_wr, ack_rise, ack_done;
   logic             mtr_fall;

   function automatic logic [31:0] lba_of(input logic [31:0]      base,
                                          input logic [TRK_W-1:0] trk,
                                          input logic [BW-1:0]    b);
      return base + (32'(trk) << BW) + 32'(b);
   endfunction

   assign req_track = half_to_track(half_track, MAX_TRK);

`ifdef C1541_FLUSH_ON_MTR_OFF_EN
   logic mtr_q;

   always_ff @(posedge clk32 or negedge reset_n) begin
      if (!reset_n) begin
         mtr_q <= 1'b0;
      end else begin
         mtr_q <= mtr;
      end
   end

   assign mtr_fall = mtr_q & ~mtr;
`else
   logic unused_mtr;
   assign unused_mtr = mtr;
   assign mtr_fall   = 1'b0;
`endif

   c1541_sd_block_xfer u_xfer (
      .clk      (clk32),
      .rst_n    (reset_n),
      .req_rd   (req_rd),
      .req_wr   (req_wr),
      .sd_ack   (sd_ack),
      .sd_rd    (sd_rd),
      .sd_wr    (sd_wr),
      .ack_rise (ack_rise),
      .done     (ack_done)
   );

   always_ff @(posedge clk32 or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         blk_q        <= '0;
         timer_q      <= '0;
         cur_track_q  <= '0;
         new_track_q  <= '0;
         prev_req_q   <= '0;
         valid_q      <= 1'b0;
         dirty_q      <= 1'b0;
         mounted_q    <= 1'b0;
         mount_pend_q <= 1'b0;
         flush_only_q <= 1'b0;
         ram_ready_q  <= 1'b0;
         sd_lba_q     <= '0;
      end else begin
         state_q      <= state_d;
         blk_q        <= blk_d;
         timer_q      <= timer_d;
         cur_track_q  <= cur_track_d;
         new_track_q  <= new_track_d;
         prev_req_q   <= req_track;
         valid_q      <= valid_d;
         dirty_q      <= dirty_d;
         mounted_q    <= mounted_d;
         mount_pend_q <= mount_pend_d;
         flush_only_q <= flush_only_d;
         ram_ready_q  <= valid_q & (state_q == IDLE);
         sd_lba_q     <= sd_lba_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      blk_d        = blk_q;
      timer_d      = timer_q;
      cur_track_d  = cur_track_q;
      new_track_d  = new_track_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      mounted_d    = mounted_q | img_mounted;
      mount_pend_d = mount_pend_q;
      flush_only_d = flush_only_q;
      sd_lba_d     = sd_lba_q;

      if (gcr_ram_we && ram_ready_q) begin
         dirty_d = 1'b1;
      end
      if (img_mounted) begin
         dirty_d = 1'b0;
         if (state_q != IDLE && state_q != SETTLE) begin
            mount_pend_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (img_mounted) begin
               valid_d = 1'b0;
               state_d = SETTLE;
               timer_d = '0;
               blk_d   = '0;
            end else if (mounted_q && (!valid_q || req_track != cur_track_q)) begin
               state_d = SETTLE;
               timer_d = '0;
               blk_d   = '0;
            end else if (mtr_fall && dirty_q && !img_readonly) begin
               state_d      = FLUSH_REQ;
               blk_d        = '0;
               flush_only_d = 1'b1;
            end
         end
         SETTLE: begin
            if (img_mounted) begin
               valid_d = 1'b0;
               timer_d = '0;
            end else if (req_track != prev_req_q) begin
               timer_d = '0;
            end else if (timer_q == SETTLE_END) begin
               blk_d = '0;
               if (dirty_q && !img_readonly && valid_q) begin
                  state_d = FLUSH_REQ;
               end else begin
                  state_d     = LOAD_REQ;
                  new_track_d = req_track;
                  valid_d     = 1'b0;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         FLUSH_REQ: begin
            if (ack_rise) begin
               state_d = FLUSH_WAIT;
            end
         end
         FLUSH_WAIT: begin
            if (ack_done) begin
               if (blk_q == LAST_BLK) begin
                  dirty_d = 1'b0;
                  blk_d   = '0;
                  if (flush_only_q) begin
                     state_d      = IDLE;
                     flush_only_d = 1'b0;
                  end else begin
                     state_d     = LOAD_REQ;
                     new_track_d = req_track;
                     valid_d     = 1'b0;
                  end
               end else begin
                  blk_d   = blk_q + BW'(1);
                  state_d = FLUSH_REQ;
               end
            end
         end
         LOAD_REQ: begin
            if (ack_rise) begin
               state_d = LOAD_WAIT;
            end
         end
         LOAD_WAIT: begin
            if (ack_done) begin
               if (req_track != new_track_q) begin
                  state_d = SETTLE;
                  blk_d   = '0;
                  timer_d = '0;
                  valid_d = 1'b0;
               end else if (blk_q == LAST_BLK) begin
                  cur_track_d = new_track_q;
                  valid_d     = 1'b1;
                  blk_d       = '0;
                  state_d     = IDLE;
               end else begin
                  blk_d   = blk_q + BW'(1);
                  state_d = LOAD_REQ;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A new image invalidates everything once the in-flight block has drained.
      if ((state_q == FLUSH_WAIT || state_q == LOAD_WAIT) && ack_done &&
          (mount_pend_q || img_mounted)) begin
         state_d      = SETTLE;
         blk_d        = '0;
         timer_d      = '0;
         valid_d      = 1'b0;
         dirty_d      = 1'b0;
         mount_pend_d = 1'b0;
         flush_only_d = 1'b0;
      end

      if (state_d == FLUSH_REQ) begin
         sd_lba_d = lba_of(img_base_lba, cur_track_q, blk_d);
      end else if (state_d == LOAD_REQ) begin
         sd_lba_d = lba_of(img_base_lba, new_track_d, blk_d);
      end
   end

   always_comb begin
      req_rd    = (state_q == LOAD_REQ);
      req_wr    = (state_q == FLUSH_REQ);
      busy      = (state_q != IDLE);
      ram_ready = ram_ready_q;
      sd_lba    = sd_lba_q;
      tbuf_addr = {blk_q, sd_buff_addr};
      tbuf_we   = sd_buff_wr & sd_ack & (state_q == LOAD_WAIT);
   end

endmodule
